bus_xfer_ctrl: RTL and testbench
================================

Name: bus_xfer_ctrl

Overview:
- Parametrised bus-transfer sequencer for the 8-bit teaching computer. It replaces hand-driven per-module OE/WE/load strobes with a debounced, one-transfer-per-press state machine.
- Each transfer moves one word from a selected source (or the programmer switches) onto the shared bus, then strobes the selected destination's write enable.
- It sits between the front-panel inputs (go, selects, switches) and the module array (PC, Acc, B register, ALU, MAR, memory, output register).

Parameters:
- DW, 8, bus data width in bits.
- NMOD, 10, number of attached modules (sources/sinks); indices 0..NMOD-1.
- SELW, 4, width of module-select fields; must satisfy 2**SELW >= NMOD.
- DB_CYCLES, 65535, consecutive stable cycles required before the debounced go changes state; minimum 2.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RESET  in  1  asynchronous, active-high reset.
- go  in  1  raw front-panel push button, asynchronous to CLK.
- HLT  in  1  halt; blocks new transfers.
- src_sel  in  SELW  source module index.
- dst_sel  in  SELW  destination module index.
- prog_mode  in  1  1 = source is prog_data instead of a module.
- prog_data  in  DW  programmer switch word.
- src_data  in  NMOD*DW  flattened module outputs; module i occupies bits [i*DW +: DW].
- oe  out  NMOD  one-hot output enable to the source module.
- we  out  NMOD  one-hot write enable to the destination module.
- bus_out  out  DW  registered bus value.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when a transfer completes.
- err  out  1  one-cycle pulse when a request is rejected.
- xfer_cnt  out  8  count of completed transfers.

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, debounced go = 0, debounce counter = 0, synchroniser flops = 0. Reset asserted mid-transfer aborts immediately; no we pulse is issued.
- go synchroniser: two-flop synchroniser produces go_s.
- Debounce counter: clears whenever go_s equals go_db. Otherwise it increments each cycle. When it reaches DB_CYCLES-1 while go_s still differs, go_db toggles and the counter clears.
- Start pulse: start = go_db rising edge, one cycle. Release produces no event.
- IDLE (busy=0): on start with HLT=0, latch src_sel, dst_sel, prog_mode and prog_data.
  - If the request is invalid, pulse err and stay in IDLE.
  - Invalid means any of: dst_sel >= NMOD; src_sel >= NMOD with prog_mode=0; src_sel == dst_sel with prog_mode=0.
  - If the request is valid, go to DRIVE.
  - start while HLT=1: dropped silently, not queued, no err.
- DRIVE (busy=1, 1 cycle): oe[src]=1, except all oe=0 when prog_mode=1. At the end of the cycle, bus_out <= prog_data or src_data slice. Go to CAPTURE.
- CAPTURE (busy=1, 1 cycle): we[dst]=1; oe stays as in DRIVE; bus_out stable. Go to DONE.
- DONE (busy=1, 1 cycle): oe=we=0, done=1, xfer_cnt increments. It wraps 255 -> 0. Go to IDLE.
- Latency: start to we = 2 cycles; start to done = 3 cycles; a transfer occupies 3 cycles.
- start pulses arriving while busy are ignored; there is no queueing.
- HLT asserted during DRIVE, CAPTURE or DONE does not stop the transfer in progress; it only blocks the next start.
- bus_out holds its last value between transfers; only DRIVE updates it.
- Latched selects are used throughout the transfer; changing src_sel or dst_sel while busy has no effect.
- oe and we are each at most one-hot at all times. oe and we may both be high only in CAPTURE, and then on different indices.

Test Plan:
All scenarios use DB_CYCLES=4, NMOD=10.
- Reset: assert RESET mid-CAPTURE -> we, oe, busy, done, bus_out, xfer_cnt all 0 on the same edge. No done follows after release.
- Debounce:
  - go glitch high for 3 cycles -> no start, busy stays 0.
  - go held high for 10 cycles -> exactly one transfer.
- Module transfer: prog_mode=0, src=1 with src_data slice 0x5A, dst=2, press go.
  - DRIVE: oe=0x002.
  - CAPTURE: we=0x004, bus_out=0x5A.
  - done one cycle later, xfer_cnt=1.
- Programmer load: prog_mode=1, prog_data=0xC3, dst=4 -> oe stays 0, bus_out=0xC3, we=0x010 for 1 cycle.
- Rejects:
  - src=dst=3 -> err pulse, no oe/we.
  - dst=12 -> err pulse.
  - HLT=1 with a valid request -> no err, no oe/we.
- Counter wrap: 256 valid transfers -> xfer_cnt returns to 0. Changing src_sel during DRIVE leaves oe and bus_out on the latched source.

Source files
------------

// File: rtl/bus_xfer_ctrl.sv
// Front-panel bus-transfer sequencer: debounces go, then runs one
// DRIVE -> CAPTURE -> DONE transfer per press from a source (or switches) to a sink.
module bus_xfer_ctrl #(
    parameter int DW        = 8,
    parameter int NMOD      = 10,
    parameter int SELW      = 4,
    parameter int DB_CYCLES = 65535
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 go,
    input  logic                 HLT,
    input  logic [SELW-1:0]      src_sel,
    input  logic [SELW-1:0]      dst_sel,
    input  logic                 prog_mode,
    input  logic [DW-1:0]        prog_data,
    input  logic [NMOD*DW-1:0]   src_data,
    output logic [NMOD-1:0]      oe,
    output logic [NMOD-1:0]      we,
    output logic [DW-1:0]        bus_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [7:0]           xfer_cnt
);

    localparam int            CW      = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
    localparam logic [SELW:0] NMOD_W  = (SELW + 1)'(NMOD);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    logic              go_meta;
    logic              go_s;
    logic              go_db;
    logic              go_db_q;
    logic [CW-1:0]     db_cnt;
    logic [SELW-1:0]   src_q;
    logic [SELW-1:0]   dst_q;
    logic              pm_q;
    logic [DW-1:0]     pd_q;
    logic              start;
    logic              req_ok;

    // Out-of-range selects decode to all-zero so a bad index can never strobe a module.
    function automatic logic [NMOD-1:0] onehot(input logic [SELW-1:0] sel);
        logic [NMOD-1:0] res;
        res = '0;
        for (int i = 0; i < NMOD; i++) begin
            res[i] = ({1'b0, sel} == (SELW + 1)'(i));
        end
        return res;
    endfunction

    function automatic logic [DW-1:0] src_mux(input logic [NMOD*DW-1:0] data,
                                              input logic [SELW-1:0]    sel);
        logic [DW-1:0] res;
        res = '0;
        for (int i = 0; i < NMOD; i++) begin
            if ({1'b0, sel} == (SELW + 1)'(i)) begin
                res = data[i*DW +: DW];
            end
        end
        return res;
    endfunction

    assign start  = go_db & ~go_db_q;
    assign req_ok = ({1'b0, dst_sel} < NMOD_W) &&
                    (prog_mode || (({1'b0, src_sel} < NMOD_W) && (src_sel != dst_sel)));

    // Two-flop synchroniser for the raw push button.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            go_meta <= 1'b0;
            go_s    <= 1'b0;
        end else begin
            go_meta <= go;
            go_s    <= go_meta;
        end
    end

    // Debouncer: go_db follows go_s only after DB_CYCLES consecutive differing cycles.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            db_cnt  <= '0;
            go_db   <= 1'b0;
            go_db_q <= 1'b0;
        end else begin
            go_db_q <= go_db;
            if (go_s == go_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                go_db  <= ~go_db;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

    // Transfer FSM; all strobes are registered on the transition into their state.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            oe       <= '0;
            we       <= '0;
            bus_out  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            xfer_cnt <= 8'd0;
            src_q    <= '0;
            dst_q    <= '0;
            pm_q     <= 1'b0;
            pd_q     <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !HLT) begin
                        src_q <= src_sel;
                        dst_q <= dst_sel;
                        pm_q  <= prog_mode;
                        pd_q  <= prog_data;
                        if (req_ok) begin
                            state <= DRIVE;
                            busy  <= 1'b1;
                            oe    <= prog_mode ? '0 : onehot(src_sel);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                DRIVE: begin
                    bus_out <= pm_q ? pd_q : src_mux(src_data, src_q);
                    we      <= onehot(dst_q);
                    state   <= CAPTURE;
                end
                CAPTURE: begin
                    oe       <= '0;
                    we       <= '0;
                    done     <= 1'b1;
                    xfer_cnt <= xfer_cnt + 8'd1;
                    state    <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    oe    <= '0;
                    we    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Scoreboard bench for bus_xfer_ctrl: presses push expected transfers/rejects,
// a negedge monitor pops and compares whenever the DUT strobes oe/we/done/err.
module tb_bus_xfer_ctrl;

    localparam int DW   = 8;
    localparam int NMOD = 10;
    localparam int SELW = 4;

    logic                CLK = 1'b0;
    logic                RESET;
    logic                go;
    logic                HLT;
    logic [SELW-1:0]     src_sel;
    logic [SELW-1:0]     dst_sel;
    logic                prog_mode;
    logic [DW-1:0]       prog_data;
    logic [NMOD*DW-1:0]  src_data;
    logic [NMOD-1:0]     oe;
    logic [NMOD-1:0]     we;
    logic [DW-1:0]       bus_out;
    logic                busy;
    logic                done;
    logic                err;
    logic [7:0]          xfer_cnt;

    bus_xfer_ctrl #(.DW(DW), .NMOD(NMOD), .SELW(SELW), .DB_CYCLES(4)) dut (
        .CLK(CLK), .RESET(RESET), .go(go), .HLT(HLT),
        .src_sel(src_sel), .dst_sel(dst_sel), .prog_mode(prog_mode),
        .prog_data(prog_data), .src_data(src_data),
        .oe(oe), .we(we), .bus_out(bus_out), .busy(busy),
        .done(done), .err(err), .xfer_cnt(xfer_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic            is_err;
        logic [NMOD-1:0] oe;
        logic [NMOD-1:0] we;
        logic [7:0]      bus;
        logic [7:0]      cnt;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] sd [NMOD];
    logic [7:0] exp_cnt;
    int         checks = 0;
    int         errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, want);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event want none", name);
    endtask

    // Monitor: compare every strobe against the head of the expectation queue.
    always @(negedge CLK) begin
        if (!RESET) begin
            if (err) begin
                if (exp_q.size() == 0 || !exp_q[0].is_err) begin
                    flag("unexpected_err");
                end else begin
                    check("err_pulse", 32'(err), 32'd1);
                    void'(exp_q.pop_front());
                end
            end
            if (oe != '0 && we == '0) begin
                if (exp_q.size() == 0 || exp_q[0].is_err) flag("unexpected_oe");
                else check("drive_oe", 32'(oe), 32'(exp_q[0].oe));
            end
            if (we != '0) begin
                if (exp_q.size() == 0 || exp_q[0].is_err) begin
                    flag("unexpected_we");
                end else begin
                    check("capture_we", 32'(we), 32'(exp_q[0].we));
                    check("capture_oe", 32'(oe), 32'(exp_q[0].oe));
                    check("capture_bus", 32'(bus_out), 32'(exp_q[0].bus));
                end
            end
            if (done) begin
                if (exp_q.size() == 0 || exp_q[0].is_err) begin
                    flag("unexpected_done");
                end else begin
                    check("done_cnt", 32'(xfer_cnt), 32'(exp_q[0].cnt));
                    check("done_oe_we", 32'({oe, we}), 32'd0);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic expect_req(input logic [3:0] s, input logic [3:0] d,
                              input logic pm, input logic [7:0] pd);
        exp_t e;
        logic ok;
        ok = (d < 4'd10) && (pm || ((s < 4'd10) && (s != d)));
        if (HLT) return;
        e.is_err = !ok;
        e.oe     = (pm || !ok) ? 10'd0 : (10'd1 << s);
        e.we     = ok ? (10'd1 << d) : 10'd0;
        e.bus    = pm ? pd : sd[s];
        if (ok) exp_cnt = exp_cnt + 8'd1;
        e.cnt    = exp_cnt;
        exp_q.push_back(e);
    endtask

    // One full press: hold long enough to debounce in, then release and let it settle.
    task automatic press(input logic [3:0] s, input logic [3:0] d,
                         input logic pm, input logic [7:0] pd, input string name);
        src_sel   = s;
        dst_sel   = d;
        prog_mode = pm;
        prog_data = pd;
        expect_req(s, d, pm, pd);
        go = 1'b1;
        repeat (12) @(negedge CLK);
        go = 1'b0;
        repeat (12) @(negedge CLK);
        check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        for (int i = 0; i < NMOD; i++) sd[i] = 8'h50 + 8'(i);
        sd[1] = 8'h5A;
        for (int i = 0; i < NMOD; i++) src_data[i*DW +: DW] = sd[i];
        RESET = 1'b1; go = 1'b0; HLT = 1'b0;
        src_sel = '0; dst_sel = '0; prog_mode = 1'b0; prog_data = '0;
        exp_cnt = 8'd0;
        repeat (3) @(negedge CLK);
        check("rst_outputs", 32'({oe, we, bus_out, busy, done, err}), 32'd0);
        check("rst_cnt", 32'(xfer_cnt), 32'd0);
        RESET = 1'b0;
        repeat (2) @(negedge CLK);

        press(4'd1, 4'd2, 1'b0, 8'h00, "module_xfer");
        press(4'd7, 4'd4, 1'b1, 8'hC3, "prog_load");
        press(4'd3, 4'd3, 1'b0, 8'h00, "rej_same");
        press(4'd0, 4'd12, 1'b0, 8'h00, "rej_dst");
        press(4'd10, 4'd0, 1'b0, 8'h00, "rej_src");
        press(4'd3, 4'd3, 1'b1, 8'h81, "prog_same_idx");
        press(4'd9, 4'd0, 1'b0, 8'h00, "edge_src9");
        press(4'd15, 4'd9, 1'b1, 8'h3C, "prog_dst9");
        HLT = 1'b1;
        press(4'd1, 4'd2, 1'b0, 8'h00, "hlt_block");
        HLT = 1'b0;

        // 3-cycle glitch must not survive the debouncer.
        go = 1'b1;
        repeat (3) @(negedge CLK);
        go = 1'b0;
        repeat (12) @(negedge CLK);
        check("glitch_busy", 32'(busy), 32'd0);
        check("glitch_cnt", 32'(xfer_cnt), 32'(exp_cnt));

        // Change src_sel during DRIVE: latched source must stay in effect.
        src_sel = 4'd1; dst_sel = 4'd2; prog_mode = 1'b0;
        expect_req(4'd1, 4'd2, 1'b0, 8'h00);
        go = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (oe != '0) break;
        end
        src_sel = 4'd5;
        repeat (11) @(negedge CLK);
        go = 1'b0;
        repeat (12) @(negedge CLK);
        check("src_change_pending", 32'(exp_q.size()), 32'd0);

        // Reset mid-CAPTURE aborts the transfer with no done afterwards.
        src_sel = 4'd2; dst_sel = 4'd6;
        expect_req(4'd2, 4'd6, 1'b0, 8'h00);
        go = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (we != '0) break;
        end
        check("pre_reset_we", 32'(we), 32'h040);
        #2;
        RESET = 1'b1;
        go = 1'b0;
        #1;
        check("midrst_outputs", 32'({oe, we, bus_out, busy, done}), 32'd0);
        check("midrst_cnt", 32'(xfer_cnt), 32'd0);
        exp_q.delete();
        exp_cnt = 8'd0;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        repeat (20) @(negedge CLK);
        check("post_rst_busy", 32'(busy), 32'd0);

        // 256 transfers wrap the counter back to zero.
        for (int i = 0; i < 256; i++) begin
            press(4'(i % 10), 4'((i + 3) % 10), 1'b0, 8'h00, "wrap");
        end
        check("wrap_cnt", 32'(xfer_cnt), 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
